// File: rtl/vga_grid_scan.sv
// VGA timing generator and grid scanner: maps each visible pixel onto a grid
// cell query, colours it from the returned occupancy and emits the frame pulse.
module vga_grid_scan #(
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33,
  parameter int          GRID_W       = 12,
  parameter int          GRID_H       = 12,
  parameter int          CELL_SHIFT   = 5,
  parameter int          ORIGIN_X     = 128,
  parameter int          ORIGIN_Y     = 48,
  parameter int          BORDER_PX    = 4,
  parameter logic [7:0]  FG_COLOR     = 8'hFC,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       coord_value,
  output logic [7:0] x_coord,
  output logic [7:0] y_coord,
  output logic       draw_finish,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int GRID_PX_W = GRID_W << CELL_SHIFT;
  localparam int GRID_PX_H = GRID_H << CELL_SHIFT;
  localparam int HS_START  = H_VISIBLE + H_FRONT;
  localparam int VS_START  = V_VISIBLE + V_FRONT;

  typedef struct packed {
    logic vis;
    logic grid;
    logic border;
    logic hs;
    logic vs;
  } pix_t;

  // stage 0: raster counters
  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last;

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      draw_finish <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      // rises together with the counters entering (0, V_VISIBLE)
      draw_finish <= h_last && (v_cnt == 10'(V_VISIBLE - 1));
    end
  end

  // stage 1 decode of the current counter position
  int         h_i, v_i;
  pix_t       s1_c;
  logic [7:0] xc_c, yc_c;

  always_comb begin
    h_i         = int'(h_cnt);
    v_i         = int'(v_cnt);
    s1_c.vis    = (h_i < H_VISIBLE) && (v_i < V_VISIBLE);
    s1_c.grid   = (h_i >= ORIGIN_X) && (h_i < ORIGIN_X + GRID_PX_W) &&
                  (v_i >= ORIGIN_Y) && (v_i < ORIGIN_Y + GRID_PX_H);
    s1_c.border = s1_c.vis && !s1_c.grid &&
                  (h_i >= ORIGIN_X - BORDER_PX) && (h_i < ORIGIN_X + GRID_PX_W + BORDER_PX) &&
                  (v_i >= ORIGIN_Y - BORDER_PX) && (v_i < ORIGIN_Y + GRID_PX_H + BORDER_PX);
    s1_c.hs     = !((h_i >= HS_START) && (h_i < HS_START + H_SYNC));
    s1_c.vs     = !((v_i >= VS_START) && (v_i < VS_START + V_SYNC));
    xc_c        = 8'hFF;
    yc_c        = 8'hFF;
    if (s1_c.grid) begin
      xc_c = 8'((h_i - ORIGIN_X) >> CELL_SHIFT);
      yc_c = 8'((v_i - ORIGIN_Y) >> CELL_SHIFT);
    end
  end

  pix_t s1;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '{vis: 1'b0, grid: 1'b0, border: 1'b0, hs: 1'b1, vs: 1'b1};
      x_coord <= 8'hFF;
      y_coord <= 8'hFF;
    end else begin
      s1      <= s1_c;
      x_coord <= xc_c;
      y_coord <= yc_c;
    end
  end

  // stage 2: coord_value answers the stage-1 query during this cycle
  logic [7:0] rgb_c;

  always_comb begin
    rgb_c = 8'h00;
    if (s1.vis) begin
      if (s1.border)
        rgb_c = BORDER_COLOR;
      else if (s1.grid)
        rgb_c = coord_value ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= 8'h00;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= rgb_c;
      hsync <= s1.hs;
      vsync <= s1.vs;
    end
  end

endmodule

// File: tb/tb_vga_grid_scan.sv
// Bench for vga_grid_scan on a scaled-down raster so whole frames fit in a
// short run; expectations come from elapsed-cycle arithmetic on the raster.
module tb_vga_grid_scan;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 3;
  localparam int GW = 4, GH = 4, CS = 3, OX = 16, OY = 8, BP = 2;
  localparam int HT    = HV + HF + HS + HB;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CELL  = 1 << CS;
  localparam int GPW   = GW * CELL;
  localparam int GPH   = GH * CELL;

  logic       vga_clk, rst_n, coord_value, noise;
  logic [7:0] x_coord, y_coord, rgb;
  logic       draw_finish, hsync, vsync;
  logic [GW*GH-1:0] occ;

  int t;
  int checks = 0;
  int errors = 0;

  vga_grid_scan #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .BORDER_PX(BP)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .coord_value(coord_value),
    .x_coord(x_coord), .y_coord(y_coord), .draw_finish(draw_finish),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) noise <= 1'($urandom);

  // grid storage answers the registered query combinationally; garbage outside
  always_comb begin
    coord_value = noise;
    if (int'(x_coord) < GW && int'(y_coord) < GH)
      coord_value = occ[int'(y_coord) * GW + int'(x_coord)];
  end

  // reference model: position of the raster p cycles after reset release
  function automatic int ph(int p); return p % HT; endfunction
  function automatic int pv(int p); return (p / HT) % VT; endfunction

  function automatic logic in_grid(int h, int v);
    return h >= OX && h < OX + GPW && v >= OY && v < OY + GPH;
  endfunction

  function automatic logic [7:0] m_rgb(int tt);
    int h, v;
    logic vis, bord;
    if (tt < 2) return 8'h00;
    h = ph(tt - 2); v = pv(tt - 2);
    vis  = h < HV && v < VV;
    bord = vis && !in_grid(h, v) && h >= OX - BP && h < OX + GPW + BP &&
           v >= OY - BP && v < OY + GPH + BP;
    if (!vis) return 8'h00;
    if (bord) return 8'hFF;
    if (in_grid(h, v)) return occ[((v - OY) / CELL) * GW + (h - OX) / CELL] ? 8'hFC : 8'h00;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_x(int tt);
    if (tt < 1 || !in_grid(ph(tt - 1), pv(tt - 1))) return 8'hFF;
    return 8'((ph(tt - 1) - OX) / CELL);
  endfunction

  function automatic logic [7:0] m_y(int tt);
    if (tt < 1 || !in_grid(ph(tt - 1), pv(tt - 1))) return 8'hFF;
    return 8'((pv(tt - 1) - OY) / CELL);
  endfunction

  function automatic logic m_hs(int tt);
    if (tt < 2) return 1'b1;
    return !(ph(tt - 2) >= HV + HF && ph(tt - 2) < HV + HF + HS);
  endfunction

  function automatic logic m_vs(int tt);
    if (tt < 2) return 1'b1;
    return !(pv(tt - 2) >= VV + VF && pv(tt - 2) < VV + VF + VS);
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    t++;
    #1;
  endtask

  task automatic test_reset();
    int budget;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      checks++;
      if (x_coord !== 8'hFF || y_coord !== 8'hFF || rgb !== 8'h00 ||
          hsync !== 1'b1 || vsync !== 1'b1 || draw_finish !== 1'b0) begin
        errors++;
        $display("FAIL reset_values: x=%h y=%h rgb=%h hs=%b vs=%b df=%b, want ff ff 00 1 1 0",
                 x_coord, y_coord, rgb, hsync, vsync, draw_finish);
      end
    end
    rst_n = 1'b1;
    t = 0;
    budget = HT * VV + 10;
    while (draw_finish !== 1'b1 && t < budget) tick();
    checks++;
    if (t !== HT * VV) begin
      errors++;
      $display("FAIL first_draw_finish: got at cycle %0d, want %0d", t, HT * VV);
    end
  endtask

  task automatic test_free_run();
    int last_df, vs_low, hs_run;
    logic prev_hs;
    last_df = t;
    vs_low  = 0;
    hs_run  = 0;
    prev_hs = hsync;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (hsync !== m_hs(t) || vsync !== m_vs(t)) begin
        errors++;
        $display("FAIL sync_model: t=%0d hs=%b vs=%b, want %b %b", t, hsync, vsync, m_hs(t), m_vs(t));
      end
      if (!vsync) vs_low++;
      if (!hsync) hs_run++;
      if (prev_hs && !hsync) begin
        checks++;
        if (t % HT !== (HV + HF + 2) % HT) begin
          errors++;
          $display("FAIL hsync_start: offset %0d, want %0d", t % HT, (HV + HF + 2) % HT);
        end
      end
      if (!prev_hs && hsync) begin
        checks++;
        if (hs_run !== HS) begin
          errors++;
          $display("FAIL hsync_width: %0d cycles, want %0d", hs_run, HS);
        end
        hs_run = 0;
      end
      prev_hs = hsync;
      if (draw_finish) begin
        checks++;
        if (t - last_df !== FRAME) begin
          errors++;
          $display("FAIL draw_finish_spacing: %0d, want %0d", t - last_df, FRAME);
        end
        last_df = t;
      end
    end
    checks++;
    if (vs_low !== 2 * VS * HT) begin
      errors++;
      $display("FAIL vsync_low_count: %0d, want %0d", vs_low, 2 * VS * HT);
    end
  endtask

  task automatic test_mapping();
    int first_cell, last_cell;
    occ = GW*GH'($urandom);
    first_cell = 0;
    last_cell  = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (x_coord !== m_x(t) || y_coord !== m_y(t)) begin
        errors++;
        $display("FAIL cell_map: t=%0d x=%h y=%h, want %h %h", t, x_coord, y_coord, m_x(t), m_y(t));
      end
      checks++;
      if (rgb !== m_rgb(t)) begin
        errors++;
        $display("FAIL rgb_random: t=%0d rgb=%h, want %h", t, rgb, m_rgb(t));
      end
      if (x_coord == 8'd0 && y_coord == 8'd0) first_cell++;
      if (x_coord == 8'(GW - 1) && y_coord == 8'(GH - 1)) last_cell++;
    end
    checks++;
    if (first_cell !== CELL * CELL || last_cell !== CELL * CELL) begin
      errors++;
      $display("FAIL cell_area: first=%0d last=%0d, want %0d", first_cell, last_cell, CELL * CELL);
    end
  endtask

  task automatic test_single_cell();
    int fg;
    occ = '0;
    occ[2 * GW + 3] = 1'b1;
    fg = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (rgb !== m_rgb(t)) begin
        errors++;
        $display("FAIL rgb_single_cell: t=%0d rgb=%h, want %h", t, rgb, m_rgb(t));
      end
      if (rgb == 8'hFC) fg++;
    end
    checks++;
    if (fg !== CELL * CELL) begin
      errors++;
      $display("FAIL fg_pixels: %0d, want %0d", fg, CELL * CELL);
    end
  endtask

  task automatic test_border_blank();
    int bord, p, h, v;
    occ = '1;
    bord = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (rgb !== m_rgb(t)) begin
        errors++;
        $display("FAIL rgb_border: t=%0d rgb=%h, want %h", t, rgb, m_rgb(t));
      end
      if (rgb == 8'hFF) bord++;
      p = t - 2; h = ph(p); v = pv(p);
      if (v == OY + 10 && (h == OX - BP || h == OX + GPW + BP - 1)) begin
        checks++;
        if (rgb !== 8'hFF) begin
          errors++;
          $display("FAIL border_edge: h=%0d rgb=%h, want ff", h, rgb);
        end
      end
      if (v == OY + 10 && (h == OX - BP - 1 || h == HV + 6)) begin
        checks++;
        if (rgb !== 8'h00) begin
          errors++;
          $display("FAIL outside_border: h=%0d rgb=%h, want 00", h, rgb);
        end
      end
    end
    checks++;
    if (bord !== (GPW + 2 * BP) * (GPH + 2 * BP) - GPW * GPH) begin
      errors++;
      $display("FAIL border_pixels: %0d, want %0d", bord, (GPW + 2 * BP) * (GPH + 2 * BP) - GPW * GPH);
    end
  endtask

  task automatic test_reset_midframe();
    int budget;
    occ = GW*GH'($urandom);
    budget = 0;
    while (!(pv(t) == 30 && ph(t) == OX + 5) && budget < 2 * FRAME) begin
      tick();
      budget++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (x_coord !== 8'hFF || y_coord !== 8'hFF || rgb !== 8'h00 ||
        hsync !== 1'b1 || vsync !== 1'b1 || draw_finish !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: x=%h y=%h rgb=%h hs=%b vs=%b df=%b, want ff ff 00 1 1 0",
               x_coord, y_coord, rgb, hsync, vsync, draw_finish);
    end
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    rst_n = 1'b1;
    t = 0;
    budget = HT * VV + 10;
    while (draw_finish !== 1'b1 && t < budget) begin
      tick();
      checks++;
      if (x_coord !== m_x(t) || y_coord !== m_y(t) || rgb !== m_rgb(t)) begin
        errors++;
        $display("FAIL restart_model: t=%0d x=%h y=%h rgb=%h, want %h %h %h",
                 t, x_coord, y_coord, rgb, m_x(t), m_y(t), m_rgb(t));
      end
    end
    checks++;
    if (t !== HT * VV) begin
      errors++;
      $display("FAIL restart_draw_finish: got at cycle %0d, want %0d", t, HT * VV);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    occ   = '0;
    t     = 0;
    test_reset();
    test_free_run();
    test_mapping();
    test_single_cell();
    test_border_blank();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
